// File: rtl/conv_result_collector.sv
// Captures convolution results on falling edges of done_conv into a frame buffer with a synchronous read port.
// Optional `RESULT_CLIP_EN: store results clipped to the 8-bit pixel range.
module conv_result_collector #(
  parameter int DATA_W     = 20,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int ADDR_W     = 14,
  parameter int SKIP_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done_conv,
  input  logic [DATA_W-1:0] result,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state, state_nx;
  logic              done_d;
  logic              fall;
  logic              arm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign fall       = done_d & ~done_conv;
  assign busy       = (state == ARMED) || (state == CAPTURE);
  assign frame_done = (state == DONE);

`ifdef RESULT_CLIP_EN
  assign wr_word = (result > DATA_W'(255)) ? DATA_W'(255) : result;
`else
  assign wr_word = result;
`endif

  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          arm      = 1'b1;
          state_nx = (SKIP_FIRST != 0) ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (!start)    state_nx = IDLE;
        else if (fall) state_nx = CAPTURE;
      end
      CAPTURE: begin
        // Abort wins over a coincident fall: nothing is stored once start drops.
        if (!start) begin
          state_nx = IDLE;
        end else if (fall) begin
          wr_en = 1'b1;
          if (count == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done_d   <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      overrun  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nx;
      done_d   <= done_conv;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
      if (arm) begin
        count   <= '0;
        wr_ptr  <= '0;
        overrun <= 1'b0;
      end
      if (wr_en) begin
        count  <= count + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if ((state == DONE) && fall) overrun <= 1'b1;
    end
  end

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector: vector table plus scoreboarded read-back sequences.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done_conv = 1'b0;
  logic [19:0] result = '0;
  logic        rd_en = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic [14:0] count;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] model_mem [0:16383];
  logic [19:0] sb_q [$];

  typedef struct {
    logic [19:0] res;
    logic [14:0] cnt;
  } vec_t;
  vec_t tbl [3];

  conv_result_collector #(
    .DATA_W(20), .IMG_W(128), .IMG_H(128), .ADDR_W(14), .SKIP_FIRST(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done_conv(done_conv), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] exp_store(input logic [19:0] v);
`ifdef RESULT_CLIP_EN
    return (v > 20'd255) ? 20'd255 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_fall(input logic [19:0] v);
    done_conv = 1'b1;
    result    = v;
    step();
    done_conv = 1'b0;
    step();
  endtask

  task automatic pop_check(input string name);
    logic [19:0] e;
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0d", name, rd_data);
    end else begin
      e = sb_q.pop_front();
      check(name, {12'd0, rd_data}, {12'd0, e});
    end
  endtask

  task automatic rd(input logic [13:0] addr, input string name);
    rd_en   = 1'b1;
    rd_addr = addr;
    sb_q.push_back(model_mem[addr]);
    step();
    rd_en = 1'b0;
    pop_check(name);
  endtask

  initial begin
    tbl[0] = '{res: 20'd7,  cnt: 15'd0};
    tbl[1] = '{res: 20'd9,  cnt: 15'd1};
    tbl[2] = '{res: 20'd11, cnt: 15'd2};

    // Reset state
    step(); step();
    check("rst_count", {17'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {12'd0, rd_data}, 32'd0);
    rst = 1'b0;
    step();

    // Table: first fall discarded, then two stored
    start = 1'b1;
    step();
    check("arm_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_fall(tbl[i].res);
      if (i > 0) model_mem[i-1] = exp_store(tbl[i].res);
      check($sformatf("tbl_count_%0d", i), {17'd0, count}, {17'd0, tbl[i].cnt});
    end
    rd(14'd0, "tbl_mem0");
    rd(14'd1, "tbl_mem1");

    // Abort from CAPTURE keeps count
    start = 1'b0;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {17'd0, count}, 32'd2);

    // Full frame: 16385 falls, result = index
    start = 1'b1;
    step();
    check("rearm_count", {17'd0, count}, 32'd0);
    for (int i = 0; i <= 16384; i++) begin
      do_fall(20'(i));
      if (i > 0) model_mem[i-1] = exp_store(20'(i));
      if (i == 16383) begin
        check("pre_last_count", {17'd0, count}, 32'd16383);
        check("pre_last_frame_done", {31'd0, frame_done}, 32'd0);
      end
    end
    check("frame_done", {31'd0, frame_done}, 32'd1);
    check("frame_busy", {31'd0, busy}, 32'd0);
    check("frame_count", {17'd0, count}, 32'd16384);
    rd(14'd0, "frame_mem0");
    rd(14'd8000, "frame_mem8000");
    rd(14'd16383, "frame_mem16383");

    // Overrun in DONE, nothing written
    do_fall(20'd99999);
    do_fall(20'd88888);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_count", {17'd0, count}, 32'd16384);
    rd(14'd0, "overrun_mem0");
    start = 1'b0;
    step();
    check("done_to_idle", {31'd0, frame_done}, 32'd0);
    check("idle_overrun_sticky", {31'd0, overrun}, 32'd1);
    start = 1'b1;
    step();
    check("rearm_overrun", {31'd0, overrun}, 32'd0);
    check("rearm_count2", {17'd0, count}, 32'd0);
    check("rearm_busy", {31'd0, busy}, 32'd1);

    // Mid-frame asynchronous reset at count = 100
    for (int i = 0; i <= 100; i++) begin
      do_fall(20'(5000 + i));
      if (i > 0) model_mem[i-1] = exp_store(20'(5000 + i));
    end
    check("mid_count", {17'd0, count}, 32'd100);
    #2;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("async_count", {17'd0, count}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_frame_done", {31'd0, frame_done}, 32'd0);
    check("async_overrun", {31'd0, overrun}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    rd(14'd50, "post_rst_mem50");

    // Same-cycle read of the write address returns old data
    start = 1'b1;
    step();
    do_fall(20'd1);
    done_conv = 1'b1;
    result    = 20'd777;
    step();
    done_conv = 1'b0;
    rd_en     = 1'b1;
    rd_addr   = 14'd0;
    sb_q.push_back(model_mem[0]);
    step();
    rd_en = 1'b0;
    model_mem[0] = exp_store(20'd777);
    pop_check("collide_old");
    rd(14'd0, "collide_new");

    // Clip boundary values (stored raw when clipping is not built in)
    do_fall(20'd300);
    model_mem[1] = exp_store(20'd300);
    do_fall(20'd255);
    model_mem[2] = exp_store(20'd255);
    do_fall(20'd0);
    model_mem[3] = exp_store(20'd0);
    check("clip_count", {17'd0, count}, 32'd4);
    rd(14'd1, "clip_300");
    rd(14'd2, "clip_255");
    rd(14'd3, "clip_0");
    step();
    check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
    check("rd_data_hold", {12'd0, rd_data}, {12'd0, model_mem[3]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Capture-side counterpart of the convolution engine's result port. Watches `done_conv` and latches each 20-bit `result` on its falling edge into an on-chip frame buffer, one word per output pixel in raster order. Signals `frame_done` once all IMG_W×IMG_H results are stored. A synchronous read port lets downstream logic drain the frame.

## Interface
- `DATA_W`, 20: width of `result` and stored words
- `IMG_W`, 128: output image width in pixels
- `IMG_H`, 128: output image height in pixels
- `ADDR_W`, 14: buffer address width; must satisfy 2^ADDR_W ≥ IMG_W×IMG_H
- `SKIP_FIRST`, 1: when 1, discard the first `done_conv` falling edge after arming (pre-computation garbage)
- `clk` input 1: single clock, rising-edge
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: level; arms capture while high
- `done_conv` input 1: engine per-pixel completion strobe
- `result` input DATA_W: engine output word
- `rd_en` input 1: read request
- `rd_addr` input ADDR_W: read address
- `rd_data` output DATA_W: read data
- `rd_valid` output 1: `rd_data` valid this cycle
- `count` output ADDR_W+1: number of results stored this frame
- `busy` output 1: state is ARMED or CAPTURE
- `frame_done` output 1: frame complete
- `overrun` output 1: sticky; a falling edge arrived in DONE

## Operation
- Edge detect: `done_d` ← `done_conv` each cycle; `fall` = `done_d & ~done_conv`. `done_d` resets to 0, so a low `done_conv` out of reset is not a fall.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: `start`=1 → ARMED if SKIP_FIRST=1, else CAPTURE; clears `count`, write pointer, `overrun`.
  - ARMED: first `fall` discarded → CAPTURE.
  - CAPTURE: each `fall` writes `result` to `mem[wr_ptr]`; `wr_ptr`++, `count`++. The write making `count` = IMG_W×IMG_H → DONE.
  - DONE: `frame_done`=1; any `fall` sets `overrun`, nothing written; `start`=0 → IDLE.
- `start` deasserted in ARMED or CAPTURE → IDLE (frame aborted, `count` retained until next arm).
- Read port is independent of state. `rd_en` at edge N gives `mem[rd_addr]` on `rd_data` and `rd_valid`=1 after edge N. A same-cycle write to the read address returns the old data. `rd_data` holds between reads.
- Reset: state IDLE; `count`, `busy`, `frame_done`, `overrun`, `rd_valid`, `rd_data`, `done_d` = 0. Buffer contents are not cleared. Reset mid-frame abandons the frame.

## Timing
- `fall` is detected at the first rising edge where `done_conv`=0 after being 1. `result` is sampled at that same edge; the engine holds `result` stable for ≥1 cycle after `done_conv` falls.
- Store latency: 1 cycle from `done_conv` low to `count` update.
- Minimum spacing between falls: 2 cycles (one high, one low sample). Every fall is captured; no back-pressure exists.
- `frame_done` rises the cycle after the final write and stays high until IDLE.
- Read latency: 1 cycle.

## Configuration
- `RESULT_CLIP_EN`
  - Defined: stored word = `result` clipped to 8-bit pixel range (values > 255 stored as 255), zero-extended to DATA_W. `result` is treated as unsigned.
  - Undefined: `result` is stored unmodified.

## Test plan
- Reset, `start`=1, SKIP_FIRST=1, 3 falls with `result` = 7, 9, 11 → first discarded; `mem[0]`=9, `mem[1]`=11, `count`=2.
- Full frame of 16385 falls, `result` = index → `frame_done` after fall 16385; `mem[16383]`=16384 (clip off); `busy`=0.
- In DONE, 2 extra falls → `overrun`=1, `count` stays 16384. Drop `start` → IDLE. Re-arm → `overrun`=0, `count`=0.
- `RESULT_CLIP_EN` defined, `result` = 300, 255, 0 → stored values 255, 255, 0.
- `rst` pulsed mid-frame at `count`=100 → all outputs 0, state IDLE. `rd_en` at address 50 still returns the pre-reset word one cycle later with `rd_valid`=1.
- `rd_en` on `wr_ptr`'s address in the same cycle as a fall → old data returned; a read next cycle returns the new word.
